// File: rtl/tff_driver.sv
// tff_driver: sequences write pulses (WE) and a read window (RE) for an
// attached ring-segment tff, decodes the first ring position where out is
// seen high, reports carry/miss, then clears the tff for one cycle.
// Optional build macro TFF_DRIVER_SYNC_EN: adds a two-flop synchronizer on
// out/carry and stretches the sample window by the synchronizer latency so
// the decoded index is unchanged.
module tff_driver #(
    parameter int RING_SEGS = 59,
    parameter int WIDTH     = 6
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_carry,
    output logic             rd_miss,
    output logic             WE,
    output logic             RE,
    output logic             tff_rstb,
    input  logic             out,
    input  logic             carry
);

`ifdef TFF_DRIVER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    // Last value of the window counter; the counter must also hold LAST_IDX+1.
    localparam int LAST_IDX = RING_SEGS - 1 + LAT;
    localparam int CW       = $clog2(LAST_IDX + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [WIDTH-1:0] r_wr_cnt;
    logic [CW-1:0]    r_idx;
    logic [CW-1:0]    w_nxt_idx;
    logic             w_re_nxt;

    logic             r_found;
    logic [WIDTH-1:0] r_pos;
    logic             r_seen_car;

    logic             w_out;
    logic             w_car;
    logic             w_smp_en;
    logic [WIDTH-1:0] w_smp_idx;
    logic             w_found_fin;
    logic [WIDTH-1:0] w_pos_fin;
    logic             w_car_fin;

    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_carry;
    logic             r_rd_miss;
    logic             r_we;
    logic             r_re;
    logic             r_trst;

`ifdef TFF_DRIVER_SYNC_EN
    logic [1:0] r_out_sync;
    logic [1:0] r_car_sync;

    // Two-flop synchronizer for the asynchronous tff outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_out_sync <= 2'b00;
            r_car_sync <= 2'b00;
        end else begin
            r_out_sync <= {r_out_sync[0], out};
            r_car_sync <= {r_car_sync[0], carry};
        end
    end

    assign w_out     = r_out_sync[1];
    assign w_car     = r_car_sync[1];
    // The first LAT window cycles still carry pre-window samples.
    assign w_smp_en  = (r_state == S_READ) && (r_idx >= CW'(LAT));
    assign w_smp_idx = WIDTH'(r_idx - CW'(LAT));
`else
    assign w_out     = out;
    assign w_car     = carry;
    assign w_smp_en  = (r_state == S_READ);
    assign w_smp_idx = WIDTH'(r_idx);
`endif

    // Result as it stands including the sample taken at the coming edge.
    assign w_found_fin = r_found | (w_smp_en & w_out);
    assign w_pos_fin   = r_found ? r_pos :
                         ((w_smp_en & w_out) ? w_smp_idx : {WIDTH{1'b0}});
    assign w_car_fin   = r_seen_car | (w_smp_en & w_car);

    // Next-state, next window index and next RE level.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = {CW{1'b0}};
        w_re_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_req) begin
                    if (wr_data != {WIDTH{1'b0}}) begin
                        w_nxt_state = S_WRITE;
                    end else begin
                        w_nxt_state = S_GAP;
                    end
                end else if (rd_req) begin
                    w_nxt_state = S_READ;
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_WRITE: begin
                if (r_wr_cnt == WIDTH'(1)) begin
                    w_nxt_state = S_GAP;
                end else begin
                    w_nxt_state = S_WRITE;
                end
            end
            S_GAP:   w_nxt_state = S_IDLE;
            S_READ: begin
                if (r_idx == CW'(LAST_IDX)) begin
                    w_nxt_state = S_CLEAR;
                end else begin
                    w_nxt_state = S_READ;
                end
            end
            S_CLEAR: w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
        if (r_state == S_READ) begin
            w_nxt_idx = r_idx + CW'(1);
        end else begin
            w_nxt_idx = {CW{1'b0}};
        end
        if ((w_nxt_state == S_READ) && (w_nxt_idx < CW'(RING_SEGS))) begin
            w_re_nxt = 1'b1;
        end else begin
            w_re_nxt = 1'b0;
        end
    end

    // State register, write-length counter and window counter.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state  <= S_IDLE;
            r_wr_cnt <= {WIDTH{1'b0}};
            r_idx    <= {CW{1'b0}};
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            if ((r_state == S_IDLE) && wr_req) begin
                r_wr_cnt <= wr_data;
            end else if (r_state == S_WRITE) begin
                r_wr_cnt <= r_wr_cnt - WIDTH'(1);
            end else begin
                r_wr_cnt <= r_wr_cnt;
            end
        end
    end

    // Window accumulators: first-hit position and sticky carry.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_found    <= 1'b0;
            r_pos      <= {WIDTH{1'b0}};
            r_seen_car <= 1'b0;
        end else if (r_state == S_READ) begin
            r_found    <= w_found_fin;
            r_pos      <= w_pos_fin;
            r_seen_car <= w_car_fin;
        end else begin
            r_found    <= 1'b0;
            r_pos      <= {WIDTH{1'b0}};
            r_seen_car <= 1'b0;
        end
    end

    // Registered control outputs, aligned with the state they belong to.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_trst  <= 1'b0;
        end else begin
            r_busy  <= (w_nxt_state != S_IDLE);
            r_valid <= (w_nxt_state == S_CLEAR);
            r_we    <= (w_nxt_state == S_WRITE);
            r_re    <= w_re_nxt;
            r_trst  <= (w_nxt_state != S_CLEAR);
        end
    end

    // Read results, loaded as the window closes and held until the next one.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rd_data  <= {WIDTH{1'b0}};
            r_rd_carry <= 1'b0;
            r_rd_miss  <= 1'b0;
        end else if ((r_state == S_READ) && (w_nxt_state == S_CLEAR)) begin
            r_rd_data  <= w_pos_fin;
            r_rd_carry <= w_car_fin;
            r_rd_miss  <= ~w_found_fin;
        end else begin
            r_rd_data  <= r_rd_data;
            r_rd_carry <= r_rd_carry;
            r_rd_miss  <= r_rd_miss;
        end
    end

    assign busy     = r_busy;
    assign rd_valid = r_valid;
    assign rd_data  = r_rd_data;
    assign rd_carry = r_rd_carry;
    assign rd_miss  = r_rd_miss;
    assign WE       = r_we;
    assign RE       = r_re;
    assign tff_rstb = r_trst;

endmodule

// File: tb/tb_tff_driver.sv
// Self-checking bench for tff_driver with a behavioural ring tff model.
// Honours TFF_DRIVER_SYNC_EN the same way as the design build.
module tb_tff_driver;

    localparam int RS = 59;
    localparam int W  = 6;
`ifdef TFF_DRIVER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rstb;
    logic         wr_req;
    logic [W-1:0] wr_data;
    logic         rd_req;
    logic         busy, rd_valid, rd_carry, rd_miss, WE, RE, tff_rstb;
    logic [W-1:0] rd_data;
    logic         out, carry;

    tff_driver #(.RING_SEGS(RS), .WIDTH(W)) dut (
        .clk(clk), .rstb(rstb), .wr_req(wr_req), .wr_data(wr_data),
        .rd_req(rd_req), .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_carry(rd_carry), .rd_miss(rd_miss), .WE(WE), .RE(RE),
        .tff_rstb(tff_rstb), .out(out), .carry(carry)
    );

    always #5 clk = ~clk;

    // Behavioural tff: tot counts WE cycles since the last clear; the token
    // sits at tot mod RS (none if nothing was written); carry once it wrapped.
    int tot = 0;
    int rc  = 0;
    always @(posedge clk or negedge tff_rstb) begin
        if (!tff_rstb) tot <= 0;
        else if (WE)   tot <= tot + 1;
    end
    always @(posedge clk) rc <= RE ? rc + 1 : 0;
    assign out   = RE && (tot > 0) && (rc == (tot % RS));
    assign carry = RE && (tot >= RS);

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observations from the last request
    int m_we, m_we_rise, m_re, m_busy, m_val, m_trst, m_vpos;
    logic [W-1:0] m_data;
    logic m_car, m_miss;

    task automatic run_req(input logic wr, input int n, input logic rd);
        int guard;
        logic prev_we;
        @(negedge clk);
        wr_req = wr; wr_data = W'(n); rd_req = rd;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        m_we = 0; m_we_rise = 0; m_re = 0; m_busy = 0; m_val = 0; m_trst = 0; m_vpos = -1;
        guard = 0; prev_we = 1'b0;
        while (busy === 1'b1 && guard < 400) begin
            if (WE === 1'b1) m_we++;
            if (WE === 1'b1 && prev_we !== 1'b1) m_we_rise++;
            prev_we = WE;
            if (RE === 1'b1) m_re++;
            if (tff_rstb === 1'b0) m_trst++;
            if (rd_valid === 1'b1) begin
                m_val++; m_vpos = m_busy;
                m_data = rd_data; m_car = rd_carry; m_miss = rd_miss;
            end
            m_busy++; guard++;
            @(negedge clk);
        end
        check("busy_timeout", 32'(guard < 400), 32'd1);
    endtask

    task automatic write_chk(input int n);
        run_req(1'b1, n, 1'b0);
        check("we_len", m_we, n);
        check("we_one_pulse", m_we_rise, (n == 0) ? 0 : 1);
        check("wr_busy_len", m_busy, n + 1);
        check("wr_no_re", m_re, 0);
        check("wr_no_valid", m_val, 0);
    endtask

    task automatic read_chk(input int e_data, input int e_car, input int e_miss);
        run_req(1'b0, 0, 1'b1);
        check("re_len", m_re, RS);
        check("rd_busy_len", m_busy, RS + LAT + 1);
        check("trst_low_len", m_trst, 1);
        check("valid_count", m_val, 1);
        check("valid_pos", m_vpos, RS + LAT);
        check("rd_data", m_data, e_data);
        check("rd_carry", m_car, e_car);
        check("rd_miss", m_miss, e_miss);
        @(negedge clk);
        check("rd_data_hold", rd_data, e_data);
    endtask

    typedef struct {
        int nw; int w0; int w1; int w2;
        int e_data; int e_car; int e_miss;
    } vec_t;
    vec_t tbl[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tot_ref;
        int nw;
        int v;
        int cnt;
        int guard;
        int seen;
        tbl[0] = '{0,  0,  0,  0,  0, 0, 1};
        tbl[1] = '{1,  8,  0,  0,  8, 0, 0};
        tbl[2] = '{2,  8, 51,  0,  0, 1, 0};
        tbl[3] = '{1,  0,  0,  0,  0, 0, 1};
        tbl[4] = '{1, 58,  0,  0, 58, 0, 0};
        tbl[5] = '{1, 59,  0,  0,  0, 1, 0};
        tbl[6] = '{2, 63, 63,  0,  8, 1, 0};
        tbl[7] = '{3, 20, 20, 20,  1, 1, 0};
        tbl[8] = '{1,  1,  0,  0,  1, 0, 0};

        rstb = 1'b0; wr_req = 1'b0; wr_data = '0; rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_carry", rd_carry, 0);
        check("rst_miss", rd_miss, 0);
        check("rst_we", WE, 0);
        check("rst_re", RE, 0);
        check("rst_trst", tff_rstb, 0);
        rstb = 1'b1;
        @(posedge clk); #1;
        check("trst_release", tff_rstb, 1);
        check("idle_busy", busy, 0);

        // Table-driven write/read vectors
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].nw > 0) write_chk(tbl[i].w0);
            if (tbl[i].nw > 1) write_chk(tbl[i].w1);
            if (tbl[i].nw > 2) write_chk(tbl[i].w2);
            read_chk(tbl[i].e_data, tbl[i].e_car, tbl[i].e_miss);
        end

        // Simultaneous requests: only the write happens
        run_req(1'b1, 3, 1'b1);
        check("both_we_len", m_we, 3);
        check("both_no_re", m_re, 0);
        check("both_no_valid", m_val, 0);
        read_chk(3, 0, 0);

        // Read request while busy is dropped
        @(negedge clk);
        wr_req = 1'b1; wr_data = W'(10);
        @(negedge clk);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        guard = 0;
        while (busy === 1'b1 && guard < 100) begin guard++; @(negedge clk); end
        check("busy_req_timeout", 32'(guard < 100), 32'd1);
        repeat (2) @(negedge clk);
        check("ignored_rd_busy", busy, 0);
        check("ignored_rd_re", RE, 0);
        read_chk(10, 0, 0);

        // Reset in the middle of the read window (index 30)
        write_chk(5);
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        cnt = 0; guard = 0;
        while (cnt < 30 && guard < 100) begin
            if (RE === 1'b1) cnt++;
            guard++;
            @(negedge clk);
        end
        check("midrd_re_before", RE, 1);
        rstb = 1'b0;
        #1;
        check("midrd_re_drop", RE, 0);
        check("midrd_busy_drop", busy, 0);
        check("midrd_trst", tff_rstb, 0);
        @(negedge clk);
        rstb = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (rd_valid === 1'b1 || RE === 1'b1) seen++;
        end
        check("midrd_no_valid", seen, 0);
        read_chk(0, 0, 1);

        // Randomized write sequences against the reference rules
        for (int it = 0; it < 25; it++) begin
            nw = $urandom_range(0, 3);
            tot_ref = 0;
            for (int k = 0; k < nw; k++) begin
                v = $urandom_range(0, 63);
                write_chk(v);
                tot_ref += v;
            end
            read_chk((tot_ref == 0) ? 0 : (tot_ref % RS),
                     (tot_ref >= RS) ? 1 : 0,
                     (tot_ref == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
